// File: rtl/mem_byte_bridge_pkg.sv
// Shared encodings and constants for the word-to-byte memory bridge.
// Imported by the bridge FSM and its byte-lane register.
package mem_byte_bridge_pkg;

    localparam int          BYTES_PER_WORD = 4;
    localparam logic [7:0]  IDLE_ADDR      = 8'hFF;
    localparam logic [5:0]  ILLEGAL_WADDR  = 6'h3F;

    localparam logic [1:0]  OP_FETCH       = 2'b00;
    localparam logic [1:0]  OP_LOAD        = 2'b01;
    localparam logic [1:0]  OP_STORE       = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_t;

    // Reserved encoding 2'b11 behaves as a load.
    function automatic logic is_read_op(input logic [1:0] op);
        return op != OP_STORE;
    endfunction

endpackage

// File: rtl/mem_byte_bridge_lanes.sv
// Four byte lanes: assemble read beats into a word, or hand out
// store bytes one lane at a time.
module word_byte_lanes
    import mem_byte_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_load_word,
    input  logic        i_we,
    input  logic [1:0]  i_idx,
    input  logic [7:0]  i_din,
    input  logic [1:0]  i_sel,
    output logic [31:0] o_word_next,
    output logic [7:0]  o_sel_byte
);

    logic [BYTES_PER_WORD-1:0][7:0] r_lanes;
    logic [BYTES_PER_WORD-1:0][7:0] w_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lanes <= '0;
        end else if (i_load) begin
            r_lanes <= i_load_word;
        end else if (i_we) begin
            r_lanes[i_idx] <= i_din;
        end
    end

    // Word as it will look once the current beat lands.
    always_comb begin
        w_next        = r_lanes;
        w_next[i_idx] = i_din;
    end

    assign o_word_next = w_next;
    assign o_sel_byte  = r_lanes[i_sel];

endmodule

// File: rtl/mem_byte_bridge.sv
// Moves 32-bit core requests over the 8-bit external bus as four
// LSB-first byte beats; address_out = IDLE_ADDR when no beat is active.
module mem_byte_bridge
    import mem_byte_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [5:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic [7:0]  address_out,
    output logic        mem_read,
    output logic        mem_write
);

    state_t      r_state;
    logic [1:0]  r_k;
    logic [1:0]  r_op;
    logic [5:0]  r_addr;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic [7:0]  r_data_out;
    logic [7:0]  r_address_out;
    logic        r_mem_read;
    logic        r_mem_write;

    logic        w_accept;
    logic        w_rd;
    logic [1:0]  w_k_next;
    logic [31:0] w_load_word;
    logic [31:0] w_word_next;
    logic [7:0]  w_sel_byte;

    assign w_accept    = (r_state == IDLE) && req_valid;
    assign w_rd        = is_read_op(r_op);
    assign w_k_next    = r_k + 2'd1;
    assign w_load_word = is_read_op(req_op) ? 32'd0 : req_wdata;

    word_byte_lanes u_lanes (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_load_word (w_load_word),
        .i_we        ((r_state == XFER) && w_rd),
        .i_idx       (r_k),
        .i_din       (data_in),
        .i_sel       (w_k_next),
        .o_word_next (w_word_next),
        .o_sel_byte  (w_sel_byte)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_k           <= 2'd0;
            r_op          <= OP_FETCH;
            r_addr        <= 6'd0;
            r_req_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= 32'd0;
            r_rsp_err     <= 1'b0;
            r_data_out    <= 8'h00;
            r_address_out <= IDLE_ADDR;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op        <= req_op;
                        r_addr      <= req_addr;
                        r_k         <= 2'd0;
                        r_req_ready <= 1'b0;
                        if (req_addr == ILLEGAL_WADDR) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= 32'd0;
                        end else begin
                            r_state       <= XFER;
                            r_address_out <= {req_addr, 2'b00};
                            r_mem_read    <= is_read_op(req_op);
                            r_mem_write   <= !is_read_op(req_op);
                            r_data_out    <= w_load_word[7:0];
                        end
                    end
                end
                XFER: begin
                    if (r_k == 2'(BYTES_PER_WORD - 1)) begin
                        r_state       <= RESP;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b0;
                        r_rsp_data    <= w_rd ? w_word_next : 32'd0;
                        r_address_out <= IDLE_ADDR;
                        r_data_out    <= 8'h00;
                        r_mem_read    <= 1'b0;
                        r_mem_write   <= 1'b0;
                    end else begin
                        r_k           <= w_k_next;
                        r_address_out <= {r_addr, w_k_next};
                        r_data_out    <= w_rd ? 8'h00 : w_sel_byte;
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_k         <= 2'd0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign data_out    = r_data_out;
    assign address_out = r_address_out;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;

endmodule

// File: doc/mem_byte_bridge.md
Name: mem_byte_bridge

Overview:
Bridges the core's 32-bit word requests (instruction fetch, data load, data store) onto the chip's 8-bit external byte bus (data_in / data_out / address_out).
Each word is moved as four byte beats, LSB first. address_out = 0xFF marks the bus as idle/stalled.
Sits between the core's fetch/LSU logic and the top-level pins. It is the stage that feeds assembled instruction words and load data into the datapath.

Parameters:
BYTES_PER_WORD, 4, byte beats per word transfer (fixed; not meant to be overridden)
IDLE_ADDR, 8'hFF, address_out value while no beat is in progress

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-low reset
req_valid  input  1  core presents a request
req_ready  output  1  bridge accepts a request this cycle
req_op  input  2  00 fetch, 01 load, 10 store, 11 reserved (treated as load)
req_addr  input  6  word address; byte address = {req_addr, 2'b00}
req_wdata  input  32  store data, captured at accept
rsp_valid  output  1  one-cycle completion pulse
rsp_data  output  32  assembled read word; 0 for store or error
rsp_err  output  1  qualifies rsp_valid; illegal address
data_in  input  8  external read byte, sampled on rising edge
data_out  output  8  external write byte
address_out  output  8  external byte address, or IDLE_ADDR
mem_read  output  1  read beat in progress
mem_write  output  1  write beat in progress

Behaviour:
- States: IDLE, XFER, RESP.
- Reset (rst=0 at a rising edge) forces the following, regardless of current state; an in-flight transfer is abandoned and no rsp_valid is issued for it:
  - state IDLE, beat counter 0
  - req_ready 1, rsp_valid 0, rsp_err 0, rsp_data 0
  - data_out 0x00, address_out 0xFF
  - mem_read 0, mem_write 0
- IDLE:
  - req_ready=1, address_out=0xFF, data_out=0x00, mem_read=mem_write=0.
  - Accept when req_valid && req_ready at the edge: latch op, addr, wdata; clear the assembly register.
  - req_addr=6'h3F is illegal, because its byte range would collide with 0xFF. Go straight to RESP with the error flag set, no bus beats.
  - Otherwise go to XFER with k=0.
- XFER (beats k=0..3, one cycle each):
  - req_ready=0.
  - address_out = {addr, k[1:0]}.
  - Read ops: mem_read=1. data_in is sampled at the edge ending beat k into bits [8k+7:8k].
  - Store: mem_write=1, data_out = wdata[8k+7:8k].
  - After beat 3, go to RESP.
- RESP (one cycle):
  - rsp_valid=1, address_out=0xFF, mem_read=mem_write=0.
  - rsp_data = assembled word for reads, 0 for store or error.
  - rsp_err=1 only for the illegal address.
  - Next state IDLE.
- Latency: accept at edge N gives rsp_valid high in cycle N+5, or N+1 for an illegal address. Throughput is one word per 6 cycles.
- Handshake rules:
  - req_* are ignored while req_ready=0. The core holds the request until accepted.
  - rsp_valid is not backpressured.
  - rsp_data / rsp_err hold their last values outside RESP.
- Simultaneous events: reset dominates accept. A req_valid during RESP is accepted only after the return to IDLE.

Decomposition:
- Shared package holds:
  - op encodings OP_FETCH=2'b00, OP_LOAD=2'b01, OP_STORE=2'b10
  - IDLE_ADDR=8'hFF and ILLEGAL_WADDR=6'h3F
  - BYTES_PER_WORD
  - state enum {IDLE, XFER, RESP}
- One natural sub-module: word_byte_lanes, a 4-lane byte register with lane write-enable from k. It provides read assembly and store-byte selection; the FSM stays in mem_byte_bridge.

Test Plan:
- Fetch, word 1, data_in 04,00,08,8D on beats: address_out 04,05,06,07 with mem_read=1 → rsp_data=0x8D080004, rsp_err=0, rsp_valid exactly 5 cycles after accept.
- Load, word 0, data_in EF,BE,AD,DE: address_out 00..03 → rsp_data=0xDEADBEEF; address_out=0xFF in the cycles before and after.
- Store 0xCAFEF00D to word 2: address_out 08,09,0A,0B with data_out 0D,F0,FE,CA, mem_write=1 for exactly 4 cycles → rsp_valid with rsp_data=0.
- req_addr=6'h3F load: no beats (address_out stays 0xFF, mem_read=0) → rsp_valid+rsp_err next cycle.
- rst=0 asserted during beat 2 of a load: next cycle address_out=0xFF, mem_read=0, req_ready=1, no rsp_valid; a fresh fetch afterwards completes correctly.
- req_valid held high across two back-to-back fetches: req_ready low through XFER/RESP, second accept in the IDLE cycle after RESP, 6-cycle spacing between rsp_valid pulses.
